// File: rtl/lr_extent_scanner.sv
// Row-by-row horizontal extent finder. For each row it probes right and then
// left of a seed column through one shared frame-store read port.
module lr_extent_scanner #(
  parameter int IMG_W     = 60,
  parameter int IMG_H     = 60,
  parameter int X_W       = 6,
  parameter int Y_W       = 6,
  parameter int ADDR_W    = 12,
  parameter int PIX_W     = 3,
  parameter int THRESHOLD = 0,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [Y_W-1:0]    top,
  input  logic [Y_W-1:0]    bottom,
  input  logic [X_W-1:0]    mid_x,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [X_W-1:0]    most_left,
  output logic [X_W-1:0]    most_right,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int               LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [X_W-1:0]   X_MAX    = X_W'(IMG_W - 1);
  localparam logic [X_W:0]     W_LIM    = (X_W+1)'(IMG_W);
  localparam logic [Y_W:0]     H_LIM    = (Y_W+1)'(IMG_H);
  localparam logic [PIX_W-1:0] THR      = PIX_W'(THRESHOLD);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    R_RD,
    R_WAIT,
    L_RD,
    L_WAIT,
    NEXT_ROW,
    DONE
  } state_t;

  state_t           state;
  logic [Y_W-1:0]   y_q;
  logic [Y_W-1:0]   bottom_q;
  logic [X_W-1:0]   x_q;
  logic [X_W-1:0]   mid_q;
  logic [LAT_W-1:0] lat_q;

  state_t           row_state;
  logic [X_W-1:0]   row_mid;
  logic [Y_W-1:0]   row_y;
  logic [X_W-1:0]   row_x;
  logic [ADDR_W-1:0] row_addr;
  logic [X_W-1:0]   x_step;
  logic [ADDR_W-1:0] step_addr;
  logic [ADDR_W-1:0] left_addr;
  logic             fg;
  logic             invalid;
  logic             saturated;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [Y_W-1:0] py,
                                                 input logic [X_W-1:0] px);
    return ADDR_W'(py) * ADDR_W'(IMG_W) + ADDR_W'(px);
  endfunction

  // Where a row begins is shared by request acceptance (row = top, seed from
  // the port) and row advance (row = y+1, seed latched).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    row_state = NEXT_ROW;
    row_mid   = (state == IDLE) ? mid_x : mid_q;
    row_y     = (state == IDLE) ? top : y_q + 1'b1;
    row_x     = row_mid;
    if (row_mid != X_MAX) begin
      row_state = R_RD;
      row_x     = row_mid + 1'b1;
    end else if (row_mid != '0) begin
      row_state = L_RD;
      row_x     = row_mid - 1'b1;
    end
    row_addr  = pix_addr(row_y, row_x);

    x_step    = (state == R_WAIT) ? x_q + 1'b1 : x_q - 1'b1;
    step_addr = pix_addr(y_q, x_step);
    left_addr = pix_addr(y_q, mid_q - 1'b1);

    fg        = rd_data > THR;
    invalid   = (top > bottom) || ({1'b0, bottom} >= H_LIM) || ({1'b0, mid_x} >= W_LIM);
    saturated = (most_left == '0) && (most_right == X_MAX);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      // NOTE: reset is synchronous; every state register, including the scan
      // counters, is cleared so an interrupted scan leaves nothing behind.
      state      <= IDLE;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      most_left  <= '0;
      most_right <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      y_q        <= '0;
      bottom_q   <= '0;
      x_q        <= '0;
      mid_q      <= '0;
      lat_q      <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every branch
      // sees the values from the start of the cycle.
      rd_en <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            y_q      <= top;
            bottom_q <= bottom;
            mid_q    <= mid_x;
            if (invalid) begin
              most_left  <= '0;
              most_right <= '0;
              done       <= 1'b1;
              err        <= 1'b1;
              state      <= DONE;
            end else begin
              most_left  <= mid_x;
              most_right <= mid_x;
              x_q        <= row_x;
              state      <= row_state;
              if (row_state != NEXT_ROW) begin
                rd_en   <= 1'b1;
                rd_addr <= row_addr;
              end
            end
          end
        end

        R_RD, L_RD: begin
          lat_q <= LAT_INIT;
          state <= (state == R_RD) ? R_WAIT : L_WAIT;
        end

        R_WAIT: begin
          if (lat_q != '0) begin
            lat_q <= lat_q - 1'b1;
          end else begin
            if (fg && (x_q > most_right)) most_right <= x_q;
            if (fg && (x_q != X_MAX)) begin
              x_q     <= x_step;
              rd_en   <= 1'b1;
              rd_addr <= step_addr;
              state   <= R_RD;
            end else if (mid_q != '0) begin
              x_q     <= mid_q - 1'b1;
              rd_en   <= 1'b1;
              rd_addr <= left_addr;
              state   <= L_RD;
            end else begin
              state <= NEXT_ROW;
            end
          end
        end

        L_WAIT: begin
          if (lat_q != '0) begin
            lat_q <= lat_q - 1'b1;
          end else begin
            if (fg && (x_q < most_left)) most_left <= x_q;
            if (fg && (x_q != '0)) begin
              x_q     <= x_step;
              rd_en   <= 1'b1;
              rd_addr <= step_addr;
              state   <= L_RD;
            end else begin
              state <= NEXT_ROW;
            end
          end
        end

        NEXT_ROW: begin
          if ((y_q == bottom_q) || saturated) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            y_q   <= row_y;
            x_q   <= row_x;
            state <= row_state;
            if (row_state != NEXT_ROW) begin
              rd_en   <= 1'b1;
              rd_addr <= row_addr;
            end
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lr_extent_scanner.sv
// Directed bench for lr_extent_scanner on an 8x8 frame: one instance with read
// latency 1 for the vector table and reset test, one with latency 3.
module tb_lr_extent_scanner;

  localparam int IMG_W  = 8;
  localparam int IMG_H  = 8;
  localparam int X_W    = 4;
  localparam int Y_W    = 4;
  localparam int ADDR_W = 7;
  localparam int PIX_W  = 3;

  logic              clk;
  logic              resetn;
  logic              start1, start3;
  logic [Y_W-1:0]    top_i, bottom_i;
  logic [X_W-1:0]    mid_i;

  logic              rd_en1, rd_en3;
  logic [ADDR_W-1:0] rd_addr1, rd_addr3;
  logic [PIX_W-1:0]  rd_data1, rd_data3;
  logic [X_W-1:0]    left1, right1, left3, right3;
  logic              busy1, busy3, done1, done3, err1, err3;

  lr_extent_scanner #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W),
    .PIX_W(PIX_W), .THRESHOLD(0), .RD_LAT(1)
  ) dut1 (
    .clk(clk), .resetn(resetn), .start(start1), .top(top_i), .bottom(bottom_i),
    .mid_x(mid_i), .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .most_left(left1), .most_right(right1), .busy(busy1), .done(done1), .err(err1)
  );

  lr_extent_scanner #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W),
    .PIX_W(PIX_W), .THRESHOLD(0), .RD_LAT(3)
  ) dut3 (
    .clk(clk), .resetn(resetn), .start(start3), .top(top_i), .bottom(bottom_i),
    .mid_x(mid_i), .rd_en(rd_en3), .rd_addr(rd_addr3), .rd_data(rd_data3),
    .most_left(left3), .most_right(right3), .busy(busy3), .done(done3), .err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame store models: data appears only in the exact cycle RD_LAT after rd_en,
  // and reads as 0 in every other cycle.
  logic [PIX_W-1:0] frame [64];
  logic [PIX_W-1:0] pipe1_d;
  logic             pipe1_v;
  logic [PIX_W-1:0] pipe3_d [3];
  logic [2:0]       pipe3_v;

  function automatic logic [PIX_W-1:0] frame_rd(input logic [ADDR_W-1:0] a);
    return (a < 7'd64) ? frame[a[5:0]] : '0;
  endfunction

  always @(posedge clk) begin
    pipe1_v    <= rd_en1;
    pipe1_d    <= frame_rd(rd_addr1);
    pipe3_v    <= {pipe3_v[1:0], rd_en3};
    pipe3_d[0] <= frame_rd(rd_addr3);
    pipe3_d[1] <= pipe3_d[0];
    pipe3_d[2] <= pipe3_d[1];
  end

  assign rd_data1 = pipe1_v ? pipe1_d : '0;
  assign rd_data3 = pipe3_v[2] ? pipe3_d[2] : '0;

  // Selected instance view used by the run task.
  logic              sel;
  logic              s_rd_en, s_busy, s_done, s_err;
  logic [ADDR_W-1:0] s_addr;
  logic [X_W-1:0]    s_left, s_right;
  assign s_rd_en = sel ? rd_en3   : rd_en1;
  assign s_addr  = sel ? rd_addr3 : rd_addr1;
  assign s_busy  = sel ? busy3    : busy1;
  assign s_done  = sel ? done3    : done1;
  assign s_err   = sel ? err3     : err1;
  assign s_left  = sel ? left3    : left1;
  assign s_right = sel ? right3   : right1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  typedef struct {
    string name;
    int    frame_id;
    int    top, bottom, mid;
    int    left, right, err, cycles, pulses, max_addr;
  } vec_t;

  typedef struct {
    int cycles, left, right, err, pulses, max_addr, b2b;
    int busy_done, busy_after, done_after, left_after, right_after;
  } res_t;

  task automatic load_frame(input int id);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        frame[y*8+x] = '0;
        case (id)
          0: if (y >= 2 && y <= 4 && x >= 3 && x <= 5) frame[y*8+x] = 3'd1;
          1: if (y == 0 && x >= 5) frame[y*8+x] = 3'd1;
          2: if (y >= 1 && y <= 6) frame[y*8+x] = 3'((x % 7) + 1);
          default: ;
        endcase
      end
  endtask

  task automatic set_start(input logic s, input logic v);
    if (s) start3 = v;
    else   start1 = v;
  endtask

  // Called at a falling edge; start is high in cycle 0, outputs of cycle c are
  // sampled at its falling edge. Also samples cycle N+1 after done.
  task automatic run(input logic s, input int t, input int b, input int m,
                     input bit poke, input int limit, output res_t r);
    logic prev_en;
    r = '{cycles: -1, left: -1, right: -1, err: -1, pulses: 0, max_addr: -1, b2b: 0,
          busy_done: -1, busy_after: -1, done_after: -1, left_after: -1, right_after: -1};
    sel      = s;
    prev_en  = 1'b0;
    top_i    = Y_W'(t);
    bottom_i = Y_W'(b);
    mid_i    = X_W'(m);
    set_start(s, 1'b1);
    for (int c = 1; c <= limit && r.cycles < 0; c++) begin
      @(negedge clk);
      set_start(s, 1'b0);
      if (poke && (c == 6 || c == 20)) begin
        top_i = '0; bottom_i = 4'd7; mid_i = '0;
        set_start(s, 1'b1);
      end
      if (s_rd_en) begin
        r.pulses++;
        if (prev_en) r.b2b++;
        if (int'(s_addr) > r.max_addr) r.max_addr = int'(s_addr);
      end
      prev_en = s_rd_en;
      if (s_done) begin
        r.cycles    = c;
        r.left      = int'(s_left);
        r.right     = int'(s_right);
        r.err       = int'(s_err);
        r.busy_done = int'(s_busy);
        if (poke) begin
          top_i = '0; bottom_i = 4'd7; mid_i = '0;
          set_start(s, 1'b1);
        end
      end
    end
    if (r.cycles >= 0) begin
      @(negedge clk);
      set_start(s, 1'b0);
      r.busy_after  = int'(s_busy);
      r.done_after  = int'(s_done);
      r.left_after  = int'(s_left);
      r.right_after = int'(s_right);
    end
  endtask

  vec_t vecs [10];
  res_t res;
  int   cnt;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           name          frm top bot mid  L  R err  N  pulses maxaddr
    vecs[0] = '{"basic",        0, 2, 4, 4, 3, 5, 0, 28, 12, 38};
    vecs[1] = '{"right_bound",  1, 0, 0, 7, 5, 7, 0,  8,  3,  6};
    vecs[2] = '{"early_exit",   2, 1, 6, 3, 0, 7, 0, 16,  7, 15};
    vecs[3] = '{"inv_order",    0, 5, 2, 3, 0, 0, 1,  1,  0, -1};
    vecs[4] = '{"inv_mid",      0, 0, 3, 8, 0, 0, 1,  1,  0, -1};
    vecs[5] = '{"inv_bottom",   0, 0, 9, 3, 0, 0, 1,  1,  0, -1};
    vecs[6] = '{"left_bound",   1, 0, 0, 0, 0, 0, 0,  4,  1,  1};
    vecs[7] = '{"empty_rows",   3, 0, 7, 4, 4, 4, 0, 41, 16, 61};
    vecs[8] = '{"single_row",   0, 3, 3, 3, 3, 5, 0, 10,  4, 30};
    vecs[9] = '{"band_mid0",    2, 1, 1, 0, 0, 7, 0, 16,  7, 15};

    resetn = 1'b0; start1 = 1'b0; start3 = 1'b0; sel = 1'b0;
    top_i = '0; bottom_i = '0; mid_i = '0;
    load_frame(3);
    repeat (3) @(negedge clk);
    check("reset.rd_en",      int'(rd_en1),   0);
    check("reset.rd_addr",    int'(rd_addr1), 0);
    check("reset.most_left",  int'(left1),    0);
    check("reset.most_right", int'(right1),   0);
    check("reset.busy",       int'(busy1),    0);
    check("reset.done",       int'(done1),    0);
    check("reset.err",        int'(err1),     0);
    check("reset.lat3_busy",  int'(busy3),    0);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      load_frame(vecs[i].frame_id);
      run(1'b0, vecs[i].top, vecs[i].bottom, vecs[i].mid, 1'b0, 200, res);
      check({vecs[i].name, ".done_cycle"}, res.cycles,     vecs[i].cycles);
      check({vecs[i].name, ".most_left"},  res.left,       vecs[i].left);
      check({vecs[i].name, ".most_right"}, res.right,      vecs[i].right);
      check({vecs[i].name, ".err"},        res.err,        vecs[i].err);
      check({vecs[i].name, ".rd_pulses"},  res.pulses,     vecs[i].pulses);
      check({vecs[i].name, ".max_addr"},   res.max_addr,   vecs[i].max_addr);
      check({vecs[i].name, ".rd_b2b"},     res.b2b,        0);
      check({vecs[i].name, ".busy_done"},  res.busy_done,  1);
      check({vecs[i].name, ".busy_after"}, res.busy_after, 0);
      check({vecs[i].name, ".done_after"}, res.done_after, 0);
      check({vecs[i].name, ".left_hold"},  res.left_after, vecs[i].left);
      check({vecs[i].name, ".right_hold"}, res.right_after, vecs[i].right);
    end

    // Reset asserted during the third probe of the basic shape.
    load_frame(0);
    sel = 1'b0;
    top_i = 4'd2; bottom_i = 4'd4; mid_i = 4'd4;
    start1 = 1'b1;
    cnt = 0;
    for (int c = 1; c <= 40 && cnt < 3; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (rd_en1) cnt++;
    end
    check("rst_mid.probe3_seen", cnt, 3);
    resetn = 1'b0;
    @(negedge clk);
    check("rst_mid.rd_en",      int'(rd_en1),   0);
    check("rst_mid.rd_addr",    int'(rd_addr1), 0);
    check("rst_mid.most_left",  int'(left1),    0);
    check("rst_mid.most_right", int'(right1),   0);
    check("rst_mid.busy",       int'(busy1),    0);
    check("rst_mid.done",       int'(done1),    0);
    check("rst_mid.err",        int'(err1),     0);
    resetn = 1'b1;
    run(1'b0, 2, 4, 4, 1'b0, 200, res);
    check("rst_rerun.done_cycle", res.cycles, 28);
    check("rst_rerun.most_left",  res.left,   3);
    check("rst_rerun.most_right", res.right,  5);
    check("rst_rerun.err",        res.err,    0);
    check("rst_rerun.rd_pulses",  res.pulses, 12);

    // Read latency 3 with start pulses while busy and in the DONE cycle.
    load_frame(0);
    run(1'b1, 2, 4, 4, 1'b1, 300, res);
    check("lat3.done_cycle", res.cycles,     52);
    check("lat3.most_left",  res.left,       3);
    check("lat3.most_right", res.right,      5);
    check("lat3.err",        res.err,        0);
    check("lat3.rd_pulses",  res.pulses,     12);
    check("lat3.rd_b2b",     res.b2b,        0);
    check("lat3.busy_after", res.busy_after, 0);
    check("lat3.left_hold",  res.left_after, 3);
    check("lat3.right_hold", res.right_after, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
